// File: rtl/w_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : w_writeback
//  Description : Writeback (W) pipeline stage. Registers the M-stage result
//                slot, selects the GRF write data, gates writes to $0 and
//                counts retired instructions.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    W_LOAD_EXT_EN - when defined, WBSel=01 returns a sign/zero-extended
//                    byte or halfword chosen by M_LoadType/M_ByteOff.
//                    When undefined, memory data passes through unchanged.
// ----------------------------------------------------------------------------
//  Ports:
//    clk, reset        rising-edge clock, synchronous active-high reset
//    M_valid           M slot holds a real instruction
//    M_RegWrite        instruction writes the GRF
//    M_WriteRegAddr    destination register
//    M_WBSel           00 ALU, 01 MEM, 10 PC+8, 11 MD
//    M_ALUResult, M_MemData, M_MDResult, M_PC   candidate data and PC
//    M_LoadType        000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
//    M_ByteOff         low address bits of the load
//    W_stall, W_flush  hold W register / insert bubble (flush wins)
//    CU_EN_RegWrite, WriteRegAddr, WriteData, PC   GRF write port
//    W_valid           W register holds a real instruction
//    W_RetireCount     count of retired instructions
// ============================================================================
module w_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_valid,
    input  logic        M_RegWrite,
    input  logic [4:0]  M_WriteRegAddr,
    input  logic [1:0]  M_WBSel,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] M_MemData,
    input  logic [31:0] M_MDResult,
    input  logic [31:0] M_PC,
    input  logic [2:0]  M_LoadType,
    input  logic [1:0]  M_ByteOff,
    input  logic        W_stall,
    input  logic        W_flush,
    output logic        CU_EN_RegWrite,
    output logic [4:0]  WriteRegAddr,
    output logic [31:0] WriteData,
    output logic [31:0] PC,
    output logic        W_valid,
    output logic [31:0] W_RetireCount
);

    localparam logic [1:0]  C_WB_ALU  = 2'b00;
    localparam logic [1:0]  C_WB_MEM  = 2'b01;
    localparam logic [1:0]  C_WB_PC8  = 2'b10;
    localparam logic [31:0] C_PC_LINK = 32'd8;

    logic        r_valid;
    logic        r_regwrite;
    logic [4:0]  r_addr;
    logic [1:0]  r_wbsel;
    logic [31:0] r_alu;
    logic [31:0] r_mem;
    logic [31:0] r_md;
    logic [31:0] r_pc;
    logic [31:0] r_retire_count;
    logic [31:0] w_load_data;

`ifdef W_LOAD_EXT_EN
    localparam logic [2:0] C_LD_LB  = 3'b001;
    localparam logic [2:0] C_LD_LBU = 3'b010;
    localparam logic [2:0] C_LD_LH  = 3'b011;
    localparam logic [2:0] C_LD_LHU = 3'b100;

    logic [2:0]  r_load_type;
    logic [1:0]  r_byte_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
`else
    // Load selection inputs have no function without the extension logic.
    logic w_unused_load;
    assign w_unused_load = ^{M_LoadType, M_ByteOff};
`endif

    // ------------------------------------------------------------------
    // W register. Reset beats flush, flush beats stall. An instruction
    // retires on any edge where it sits valid in W and is not held, even
    // if a flush replaces the incoming slot on that same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_regwrite     <= 1'b0;
            r_addr         <= 5'd0;
            r_wbsel        <= 2'b00;
            r_alu          <= 32'd0;
            r_mem          <= 32'd0;
            r_md           <= 32'd0;
            r_pc           <= 32'd0;
            r_retire_count <= 32'd0;
`ifdef W_LOAD_EXT_EN
            r_load_type    <= 3'd0;
            r_byte_off     <= 2'd0;
`endif
        end else begin
            if (W_flush) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_addr     <= 5'd0;
                r_wbsel    <= 2'b00;
                r_alu      <= 32'd0;
                r_mem      <= 32'd0;
                r_md       <= 32'd0;
                r_pc       <= 32'd0;
`ifdef W_LOAD_EXT_EN
                r_load_type <= 3'd0;
                r_byte_off  <= 2'd0;
`endif
            end else if (!W_stall) begin
                r_valid    <= M_valid;
                r_regwrite <= M_RegWrite;
                r_addr     <= M_WriteRegAddr;
                r_wbsel    <= M_WBSel;
                r_alu      <= M_ALUResult;
                r_mem      <= M_MemData;
                r_md       <= M_MDResult;
                r_pc       <= M_PC;
`ifdef W_LOAD_EXT_EN
                r_load_type <= M_LoadType;
                r_byte_off  <= M_ByteOff;
`endif
            end

            if (r_valid && !W_stall) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load data formatting
    // ------------------------------------------------------------------
`ifdef W_LOAD_EXT_EN
    always_comb begin
        w_byte = r_mem[7:0];
        case (r_byte_off)
            2'd0:    w_byte = r_mem[7:0];
            2'd1:    w_byte = r_mem[15:8];
            2'd2:    w_byte = r_mem[23:16];
            default: w_byte = r_mem[31:24];
        endcase
        // Halfword choice uses only the upper offset bit.
        w_half = r_byte_off[1] ? r_mem[31:16] : r_mem[15:0];

        w_load_data = r_mem;
        case (r_load_type)
            C_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            C_LD_LBU: w_load_data = {24'd0, w_byte};
            C_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            C_LD_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = r_mem;
        endcase
    end
`else
    assign w_load_data = r_mem;
`endif

    // ------------------------------------------------------------------
    // GRF write port
    // ------------------------------------------------------------------
    always_comb begin
        case (r_wbsel)
            C_WB_ALU: WriteData = r_alu;
            C_WB_MEM: WriteData = w_load_data;
            C_WB_PC8: WriteData = r_pc + C_PC_LINK;
            default:  WriteData = r_md;
        endcase
    end

    assign CU_EN_RegWrite = r_valid & r_regwrite & (r_addr != 5'd0);
    assign WriteRegAddr   = r_addr;
    assign PC             = r_pc;
    assign W_valid        = r_valid;
    assign W_RetireCount  = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_w_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w_writeback
//  Description : Directed self-checking bench for w_writeback. Expected
//                values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_w_writeback;

    logic        clk;
    logic        reset;
    logic        M_valid;
    logic        M_RegWrite;
    logic [4:0]  M_WriteRegAddr;
    logic [1:0]  M_WBSel;
    logic [31:0] M_ALUResult;
    logic [31:0] M_MemData;
    logic [31:0] M_MDResult;
    logic [31:0] M_PC;
    logic [2:0]  M_LoadType;
    logic [1:0]  M_ByteOff;
    logic        W_stall;
    logic        W_flush;
    logic        CU_EN_RegWrite;
    logic [4:0]  WriteRegAddr;
    logic [31:0] WriteData;
    logic [31:0] PC;
    logic        W_valid;
    logic [31:0] W_RetireCount;

    int n_vec  = 0;
    int n_miss = 0;

    w_writeback dut (
        .clk            (clk),
        .reset          (reset),
        .M_valid        (M_valid),
        .M_RegWrite     (M_RegWrite),
        .M_WriteRegAddr (M_WriteRegAddr),
        .M_WBSel        (M_WBSel),
        .M_ALUResult    (M_ALUResult),
        .M_MemData      (M_MemData),
        .M_MDResult     (M_MDResult),
        .M_PC           (M_PC),
        .M_LoadType     (M_LoadType),
        .M_ByteOff      (M_ByteOff),
        .W_stall        (W_stall),
        .W_flush        (W_flush),
        .CU_EN_RegWrite (CU_EN_RegWrite),
        .WriteRegAddr   (WriteRegAddr),
        .WriteData      (WriteData),
        .PC             (PC),
        .W_valid        (W_valid),
        .W_RetireCount  (W_RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle to the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] a,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] md,
                         input logic [31:0] pc, input logic [2:0] lt,
                         input logic [1:0] off);
        M_valid        = v;
        M_RegWrite     = rw;
        M_WriteRegAddr = a;
        M_WBSel        = sel;
        M_ALUResult    = alu;
        M_MemData      = mem;
        M_MDResult     = md;
        M_PC           = pc;
        M_LoadType     = lt;
        M_ByteOff      = off;
    endtask

    initial begin
        reset   = 1'b1;
        W_stall = 1'b0;
        W_flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0);
        @(negedge clk);
        step();
        step();

        // Reset state
        chk("rst_wen",   {31'd0, CU_EN_RegWrite}, 32'd0);
        chk("rst_addr",  {27'd0, WriteRegAddr},   32'd0);
        chk("rst_data",  WriteData,               32'd0);
        chk("rst_pc",    PC,                      32'd0);
        chk("rst_valid", {31'd0, W_valid},        32'd0);
        chk("rst_cnt",   W_RetireCount,           32'd0);
        reset = 1'b0;

        // ALU write to $8
        drive(1'b1, 1'b1, 5'd8, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_3000, 3'd0, 2'd0);
        step();
        chk("alu_wen",   {31'd0, CU_EN_RegWrite}, 32'd1);
        chk("alu_addr",  {27'd0, WriteRegAddr},   32'd8);
        chk("alu_data",  WriteData,               32'h0000_1234);
        chk("alu_pc",    PC,                      32'h0000_3000);
        chk("alu_cnt0",  W_RetireCount,           32'd0);

        // Write to $0 is suppressed but still a valid instruction
        drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_5555, 32'h0, 32'h0, 32'h0000_3004, 3'd0, 2'd0);
        step();
        chk("r0_cnt",    W_RetireCount,           32'd1);
        chk("r0_wen",    {31'd0, CU_EN_RegWrite}, 32'd0);
        chk("r0_valid",  {31'd0, W_valid},        32'd1);

        // jal: PC+8 wraps
        drive(1'b1, 1'b1, 5'd31, 2'b10, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0);
        step();
        chk("jal_data",  WriteData,               32'h0000_0004);
        chk("jal_addr",  {27'd0, WriteRegAddr},   32'd31);
        chk("jal_wen",   {31'd0, CU_EN_RegWrite}, 32'd1);
        chk("jal_cnt",   W_RetireCount,           32'd2);

        // Stall three cycles while M changes
        W_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'(i + 5), 2'b11, 32'hDEAD_0000 + 32'(i), 32'h0,
                  32'hBEEF_0000 + 32'(i), 32'h0000_4000 + 32'(i), 3'd0, 2'd0);
            step();
            chk("stl_data",  WriteData,             32'h0000_0004);
            chk("stl_addr",  {27'd0, WriteRegAddr}, 32'd31);
            chk("stl_pc",    PC,                    32'hFFFF_FFFC);
            chk("stl_cnt",   W_RetireCount,         32'd2);
        end

        // Flush wins over stall
        W_flush = 1'b1;
        step();
        chk("fl_valid",  {31'd0, W_valid},        32'd0);
        chk("fl_wen",    {31'd0, CU_EN_RegWrite}, 32'd0);
        chk("fl_data",   WriteData,               32'd0);
        chk("fl_cnt",    W_RetireCount,           32'd2);
        W_flush = 1'b0;
        W_stall = 1'b0;

        // MD result select
        drive(1'b1, 1'b1, 5'd2, 2'b11, 32'h1, 32'h2, 32'hCAFE_F00D, 32'h0000_5000, 3'd0, 2'd0);
        step();
        chk("md_data",   WriteData,               32'hCAFE_F00D);

        // Load formatting
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0, 32'h8081_7F80, 32'h0, 32'h0000_6000, 3'b001, 2'd0);
        step();
`ifdef W_LOAD_EXT_EN
        chk("lb_off0",   WriteData,               32'hFFFF_FF80);
`else
        chk("lb_off0",   WriteData,               32'h8081_7F80);
`endif
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0, 32'h8081_7F80, 32'h0, 32'h0000_6004, 3'b010, 2'd3);
        step();
`ifdef W_LOAD_EXT_EN
        chk("lbu_off3",  WriteData,               32'h0000_0080);
`else
        chk("lbu_off3",  WriteData,               32'h8081_7F80);
`endif
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0, 32'h8081_7F80, 32'h0, 32'h0000_6008, 3'b011, 2'd2);
        step();
`ifdef W_LOAD_EXT_EN
        chk("lh_off2",   WriteData,               32'hFFFF_8081);
`else
        chk("lh_off2",   WriteData,               32'h8081_7F80);
`endif
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0, 32'h8081_7F80, 32'h0, 32'h0000_600C, 3'b100, 2'd0);
        step();
`ifdef W_LOAD_EXT_EN
        chk("lhu_off0",  WriteData,               32'h0000_7F80);
`else
        chk("lhu_off0",  WriteData,               32'h8081_7F80);
`endif
        // md, lb, lbu, lh retired so far on top of the earlier two
        chk("ld_cnt",    W_RetireCount,           32'd6);

        // Counter wrap: preload all-ones, lhu in W retires on next edge
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
        step();
        chk("wrap_cnt",  W_RetireCount,           32'd0);

        // Reset during a stalled valid instruction
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0077, 32'h0, 32'h0, 32'h0000_7000, 3'd0, 2'd0);
        step();
        chk("pre_wen",   {31'd0, CU_EN_RegWrite}, 32'd1);
        W_stall = 1'b1;
        step();
        chk("hold_wen",  {31'd0, CU_EN_RegWrite}, 32'd1);
        chk("hold_cnt",  W_RetireCount,           32'd0);
        reset = 1'b1;
        step();
        chk("rs_wen",    {31'd0, CU_EN_RegWrite}, 32'd0);
        chk("rs_valid",  {31'd0, W_valid},        32'd0);
        chk("rs_addr",   {27'd0, WriteRegAddr},   32'd0);
        chk("rs_cnt",    W_RetireCount,           32'd0);
        reset   = 1'b0;
        W_stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
